// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard: tracks the destination tags of in-flight instructions
// from EXE (slot 0) to WB (slot DEPTH-1) and derives stall, forward-select and freeze controls.
module pipe_scoreboard #(
   parameter int REG_W         = 4,
   parameter int DEPTH         = 3,
   parameter int LOAD_FWD_SLOT = 2,
   parameter int CNT_W         = 16,
   parameter int SEL_W         = $clog2(DEPTH),
   parameter int INF_W         = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forward_mode,
   input  logic             id_valid,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic [REG_W-1:0] id_dest,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_use_src1,
   input  logic             id_two_src,
   input  logic             flush,
   input  logic             mem_stall,
   output logic             hazard,
   output logic             freeze_front,
   output logic             freeze_back,
   output logic [SEL_W-1:0] sel_src1,
   output logic [SEL_W-1:0] sel_src2,
   output logic [INF_W-1:0] inflight_wr,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic             valid;
      logic             wb_en;
      logic             mem_r;
      logic [REG_W-1:0] dest;
   } slot_t;

   slot_t            slot_q [DEPTH];
   slot_t            slot_d [DEPTH];
   logic [REG_W-1:0] ex_src1_q, ex_src1_d;
   logic [REG_W-1:0] ex_src2_q, ex_src2_d;
   logic             ex_use_src1_q, ex_use_src1_d;
   logic             ex_two_src_q, ex_two_src_d;
   logic [INF_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             raw;
   logic             bubble;
   logic             bad_fwd;

   function automatic logic tag_match(input slot_t s, input logic [REG_W-1:0] r);
      return s.valid & s.wb_en & (s.dest == r);
   endfunction

   // Without forwarding every producer short of WB blocks; with forwarding only
   // loads too young to have their data yet block.
   always_comb begin
      raw = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((id_use_src1 && tag_match(slot_q[k], id_src1)) ||
             (id_two_src  && tag_match(slot_q[k], id_src2))) begin
            if (forward_mode) begin
               if ((k < LOAD_FWD_SLOT - 1) && slot_q[k].mem_r) raw = 1'b1;
            end else begin
               if (k < DEPTH - 1) raw = 1'b1;
            end
         end
      end
   end

   assign hazard       = raw & id_valid & ~flush;
   assign bubble       = hazard | flush | ~id_valid;
   assign freeze_front = hazard | mem_stall;
   assign freeze_back  = mem_stall;

   always_comb begin
      for (int k = 0; k < DEPTH; k++) slot_d[k] = slot_q[k];
      ex_src1_d     = ex_src1_q;
      ex_src2_d     = ex_src2_q;
      ex_use_src1_d = ex_use_src1_q;
      ex_two_src_d  = ex_two_src_q;
      if (!mem_stall) begin
         for (int k = 1; k < DEPTH; k++) slot_d[k] = slot_q[k-1];
         if (bubble) begin
            slot_d[0]     = '0;
            ex_src1_d     = '0;
            ex_src2_d     = '0;
            ex_use_src1_d = 1'b0;
            ex_two_src_d  = 1'b0;
         end else begin
            slot_d[0].valid = 1'b1;
            slot_d[0].wb_en = id_wb_en;
            slot_d[0].mem_r = id_mem_r_en;
            slot_d[0].dest  = id_dest;
            ex_src1_d       = id_src1;
            ex_src2_d       = id_src2;
            ex_use_src1_d   = id_use_src1;
            ex_two_src_d    = id_two_src;
         end
      end
      inflight_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (slot_d[k].valid && slot_d[k].wb_en) inflight_d = inflight_d + INF_W'(1);
      end
   end

   always_comb begin
      if ((hazard || mem_stall) && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      else
         stall_cnt_d = stall_cnt_q;
   end

   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      sel_src1 = '0;
      sel_src2 = '0;
      if (forward_mode && slot_q[0].valid) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            if (ex_use_src1_q && tag_match(slot_q[k], ex_src1_q)) sel_src1 = SEL_W'(k);
            if (ex_two_src_q  && tag_match(slot_q[k], ex_src2_q)) sel_src2 = SEL_W'(k);
         end
      end
   end

   always_comb begin
      bad_fwd = 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
         if ((k < LOAD_FWD_SLOT) && slot_q[k].mem_r &&
             ((sel_src1 == SEL_W'(k)) || (sel_src2 == SEL_W'(k)))) bad_fwd = 1'b1;
      end
   end

   a_no_early_load_fwd: assert property (@(posedge clk) disable iff (!rst) !bad_fwd);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
         ex_src1_q     <= '0;
         ex_src2_q     <= '0;
         ex_use_src1_q <= 1'b0;
         ex_two_src_q  <= 1'b0;
         inflight_q    <= '0;
         stall_cnt_q   <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
         ex_src1_q     <= ex_src1_d;
         ex_src2_q     <= ex_src2_d;
         ex_use_src1_q <= ex_use_src1_d;
         ex_two_src_q  <= ex_two_src_d;
         inflight_q    <= inflight_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign inflight_wr = inflight_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: stall, forward-select, freeze, flush,
// saturation (narrow counter) and mid-operation reset.
module tb_pipe_scoreboard;
   localparam int REG_W = 4;
   localparam int DEPTH = 3;
   localparam int LFS   = 2;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             forward_mode = 1'b0;
   logic             id_valid = 1'b0;
   logic             id_wb_en = 1'b0;
   logic             id_mem_r_en = 1'b0;
   logic [REG_W-1:0] id_dest = '0;
   logic [REG_W-1:0] id_src1 = '0;
   logic [REG_W-1:0] id_src2 = '0;
   logic             id_use_src1 = 1'b0;
   logic             id_two_src = 1'b0;
   logic             flush = 1'b0;
   logic             mem_stall = 1'b0;
   logic             hazard;
   logic             freeze_front;
   logic             freeze_back;
   logic [1:0]       sel_src1;
   logic [1:0]       sel_src2;
   logic [1:0]       inflight_wr;
   logic [CNT_W-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_scoreboard #(
      .REG_W(REG_W), .DEPTH(DEPTH), .LOAD_FWD_SLOT(LFS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .forward_mode(forward_mode),
      .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
      .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_two_src(id_two_src),
      .flush(flush), .mem_stall(mem_stall),
      .hazard(hazard), .freeze_front(freeze_front), .freeze_back(freeze_back),
      .sel_src1(sel_src1), .sel_src2(sel_src2),
      .inflight_wr(inflight_wr), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_valid = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
      id_dest = '0; id_src1 = '0; id_src2 = '0;
      id_use_src1 = 1'b0; id_two_src = 1'b0;
   endtask

   task automatic issue(input logic wb, input logic mr, input logic [3:0] d,
                        input logic [3:0] s1, input logic [3:0] s2,
                        input logic u1, input logic t2);
      id_valid = 1'b1; id_wb_en = wb; id_mem_r_en = mr;
      id_dest = d; id_src1 = s1; id_src2 = s2;
      id_use_src1 = u1; id_two_src = t2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (3) tick();
   endtask

   initial begin
      #2 rst = 1'b0;
      #8;
      chk("rst_hazard", hazard, 0);
      chk("rst_sel1", sel_src1, 0);
      chk("rst_inflight", inflight_wr, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      #2 rst = 1'b1;
      tick();

      // T1: stall-only, ADD r1 then SUB r2,r1,r4
      forward_mode = 1'b0;
      issue(1, 0, 1, 2, 3, 1, 1);
      #1 chk("t1_add_hz", hazard, 0);
      tick();
      chk("t1_inflight_add", inflight_wr, 1);
      issue(1, 0, 2, 1, 4, 1, 1);
      #1 chk("t1_hz_c1", hazard, 1);
      chk("t1_ff_c1", freeze_front, 1);
      tick();
      #1 chk("t1_hz_c2", hazard, 1);
      tick();
      #1 chk("t1_hz_c3", hazard, 0);
      tick();
      idle();
      #1 chk("t1_sel1", sel_src1, 0);
      chk("t1_inflight", inflight_wr, 1);
      chk("t1_stall_cnt", stall_cnt, 2);
      drain();
      chk("t1_drained", inflight_wr, 0);

      // T2: forwarding, back-to-back then with one NOP gap
      forward_mode = 1'b1;
      issue(1, 0, 1, 2, 3, 1, 1);
      tick();
      issue(1, 0, 2, 1, 4, 1, 1);
      #1 chk("t2_hz", hazard, 0);
      tick();
      idle();
      #1 chk("t2_sel1_b2b", sel_src1, 1);
      chk("t2_sel2_b2b", sel_src2, 0);
      chk("t2_inflight", inflight_wr, 2);
      issue(1, 0, 1, 2, 3, 1, 1);
      tick();
      idle();
      tick();
      issue(1, 0, 2, 1, 4, 1, 1);
      #1 chk("t2_hz_gap", hazard, 0);
      tick();
      idle();
      #1 chk("t2_sel1_gap", sel_src1, 2);
      drain();

      // T3: load-use, LDR r3 then ADD r4,r3,r5
      issue(1, 1, 3, 0, 0, 1, 0);
      tick();
      issue(1, 0, 4, 3, 5, 1, 1);
      #1 chk("t3_hz_c1", hazard, 1);
      tick();
      #1 chk("t3_hz_c2", hazard, 0);
      tick();
      idle();
      #1 chk("t3_sel1", sel_src1, 2);
      chk("t3_stall_cnt", stall_cnt, 3);
      drain();

      // T4: two MOV r5, then ADD r6,r5,r5: youngest producer wins
      issue(1, 0, 5, 0, 7, 0, 1);
      tick();
      issue(1, 0, 5, 0, 8, 0, 1);
      tick();
      issue(1, 0, 6, 5, 5, 1, 1);
      #1 chk("t4_hz", hazard, 0);
      tick();
      idle();
      #1 chk("t4_sel1", sel_src1, 1);
      chk("t4_sel2", sel_src2, 1);
      drain();

      // T5: conflicting ID with flush in the same cycle
      forward_mode = 1'b0;
      issue(1, 0, 1, 2, 3, 1, 1);
      tick();
      issue(1, 0, 2, 1, 4, 1, 1);
      flush = 1'b1;
      #1 chk("t5_hz", hazard, 0);
      chk("t5_ff", freeze_front, 0);
      tick();
      flush = 1'b0;
      idle();
      #1 chk("t5_inflight", inflight_wr, 1);
      chk("t5_stall_cnt", stall_cnt, 3);
      drain();

      // T7: hazard and mem_stall together count once; pipe holds
      issue(1, 0, 1, 2, 3, 1, 1);
      tick();
      issue(1, 0, 2, 1, 4, 1, 1);
      mem_stall = 1'b1;
      #1 chk("t7_hz", hazard, 1);
      chk("t7_fb", freeze_back, 1);
      tick();
      chk("t7_stall_cnt", stall_cnt, 4);
      chk("t7_inflight_hold", inflight_wr, 1);
      mem_stall = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drain();
      chk("t7_drained", inflight_wr, 0);

      // T6: forwarding under mem_stall, counter saturation, reset mid-op
      forward_mode = 1'b1;
      issue(1, 0, 1, 2, 3, 1, 1);
      tick();
      issue(1, 0, 2, 1, 4, 1, 1);
      tick();
      idle();
      mem_stall = 1'b1;
      #1 chk("t6_ff", freeze_front, 1);
      chk("t6_fb", freeze_back, 1);
      tick();
      chk("t6_sel1_s1", sel_src1, 1);
      tick();
      tick();
      chk("t6_sel1_s3", sel_src1, 1);
      chk("t6_inflight", inflight_wr, 2);
      chk("t6_stall_cnt", stall_cnt, 7);
      tick();
      chk("t6_stall_sat", stall_cnt, 7);
      mem_stall = 1'b0;
      rst = 1'b0;
      #1 chk("t6_rst_sel1", sel_src1, 0);
      chk("t6_rst_inflight", inflight_wr, 0);
      chk("t6_rst_cnt", stall_cnt, 0);
      chk("t6_rst_ff", freeze_front, 0);
      chk("t6_rst_hz", hazard, 0);
      #1 rst = 1'b1;
      forward_mode = 1'b0;
      issue(1, 0, 2, 1, 4, 1, 1);
      #1 chk("t6_post_rst_hz", hazard, 0);
      tick();
      chk("t6_post_rst_inflight", inflight_wr, 1);
      chk("t6_post_rst_cnt", stall_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
